// File: rtl/thread_scheduler_pkg.sv
// Shared types and constants for the two-thread switch-on-event scheduler.
// Provides the thread ID type, the scheduler FSM state encoding, the
// thread count and a small helper that names the "other" thread.
package thread_scheduler_pkg;

   localparam int NUM_THREADS = 2;

   typedef logic [0:0] thread_id_t;

   typedef enum logic [1:0] {
      S_RUN      = 2'd0,
      S_SWITCH   = 2'd1,
      S_IDLE     = 2'd2,
      S_REDIRECT = 2'd3
   } sched_state_e;

   // With exactly two threads the partner of a thread is its complement.
   function automatic thread_id_t otherThread(input thread_id_t tid);
      return ~tid;
   endfunction

endpackage

// File: rtl/thread_scheduler_if.sv
// Thread-control bundle between the scheduler and the pipeline/fetch unit.
// Inputs to the scheduler (i_*): switch request with restart PC, hazard
// stall, event completion with its thread ID.
// Outputs from the scheduler (o_*): switch pulse, active thread, resume PC
// per thread, flush, idle, redirect pulse with redirect PC, blocked flags.
// The slave modport is the scheduler side, master is the pipeline side.
interface thread_scheduler_if
   import thread_scheduler_pkg::*;
#(
   parameter int ADDR_WIDTH = 26
);

   logic                  i_switch_req;
   logic [ADDR_WIDTH-1:0] i_restart_pc;
   logic                  i_stall;
   logic                  i_event_done;
   thread_id_t            i_event_tid;

   logic                  o_thread_switch;
   thread_id_t            o_thread_id;
   logic [ADDR_WIDTH-1:0] o_resume_pc [NUM_THREADS];
   logic                  o_flush;
   logic                  o_idle;
   logic                  o_redirect;
   logic [ADDR_WIDTH-1:0] o_redirect_pc;
   logic [1:0]            o_blocked;

   modport slave (
      input  i_switch_req, i_restart_pc, i_stall, i_event_done, i_event_tid,
      output o_thread_switch, o_thread_id, o_resume_pc, o_flush, o_idle,
             o_redirect, o_redirect_pc, o_blocked
   );

   modport master (
      output i_switch_req, i_restart_pc, i_stall, i_event_done, i_event_tid,
      input  o_thread_switch, o_thread_id, o_resume_pc, o_flush, o_idle,
             o_redirect, o_redirect_pc, o_blocked
   );

endinterface

// File: rtl/thread_scheduler_quantum_timer.sv
// Time-quantum counter for preemptive thread switching.
// Ports: clk/rst (synchronous, active-high), count_en advances the count,
// clear zeroes it (and wins over count_en), expired is high while the
// count sits at QUANTUM-1. The count saturates there rather than wrapping.
module quantum_timer #(
   parameter int QUANTUM = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic count_en,
   input  logic clear,
   output logic expired
);

   localparam int CW = $clog2(QUANTUM);
   localparam logic [CW-1:0] LAST = CW'(QUANTUM - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Next count: clear has priority; otherwise count up until saturated.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (count_en && (count_q != LAST)) begin
         count_d = count_q + 1'b1;
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = (count_q == LAST);

endmodule

// File: rtl/thread_scheduler.sv
// Two-thread switch-on-event scheduler. Holds the active thread ID, a resume
// PC per thread and per-thread blocked flags, and sequences switch, idle and
// redirect. Switches on a long-latency event or when the quantum expires.
// Ports: clk, rst (synchronous, active-high), bus (thread_scheduler_if.slave)
// carrying all thread-control inputs and outputs. Every output is decoded
// from registered state only.
module thread_scheduler
   import thread_scheduler_pkg::*;
#(
   parameter int ADDR_WIDTH = 26,
   parameter int QUANTUM    = 64
) (
   input logic              clk,
   input logic              rst,
   thread_scheduler_if.slave bus
);

   localparam logic [1:0] ST_RUN      = S_RUN;
   localparam logic [1:0] ST_SWITCH   = S_SWITCH;
   localparam logic [1:0] ST_IDLE     = S_IDLE;
   localparam logic [1:0] ST_REDIRECT = S_REDIRECT;

   logic [1:0]            state_q, state_d;
   thread_id_t            tid_q, tid_d;
   logic [ADDR_WIDTH-1:0] pc_q [NUM_THREADS];
   logic [ADDR_WIDTH-1:0] pc_d [NUM_THREADS];
   logic [1:0]            blocked_q, blocked_d;
   logic [1:0]            blockedPost;
   thread_id_t            otherTid;
   logic                  expired;

   assign otherTid = otherThread(tid_q);

   // The timer only advances during unstalled run cycles, and is held at
   // zero whenever the next state is not RUN so it restarts fresh after any
   // switch, idle or redirect.
   quantum_timer #(
      .QUANTUM (QUANTUM)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .count_en ((state_q == ST_RUN) && !bus.i_stall),
      .clear    (state_d != ST_RUN),
      .expired  (expired)
   );

   // Next-state logic. An event completion clears its thread's blocked flag
   // in every state, and the switch decision in RUN looks at that already
   // cleared value so a simultaneous completion lets us switch instead of
   // going idle. A new request from the active thread re-blocks it even if
   // a completion for the same thread lands in the same cycle.
   always_comb begin
      state_d     = state_q;
      tid_d       = tid_q;
      pc_d        = pc_q;
      blockedPost = blocked_q;
      if (bus.i_event_done) begin
         blockedPost[bus.i_event_tid] = 1'b0;
      end
      blocked_d = blockedPost;
      case (state_q)
         ST_RUN: begin
            if (bus.i_switch_req) begin
               pc_d[tid_q]      = bus.i_restart_pc;
               blocked_d[tid_q] = 1'b1;
               state_d          = blockedPost[otherTid] ? ST_IDLE : ST_SWITCH;
            end else if (expired && !bus.i_stall && !blockedPost[otherTid]) begin
               pc_d[tid_q] = bus.i_restart_pc;
               state_d     = ST_SWITCH;
            end
         end
         ST_SWITCH: begin
            tid_d   = otherTid;
            state_d = ST_RUN;
         end
         ST_IDLE: begin
            if (bus.i_event_done) begin
               state_d = (bus.i_event_tid != tid_q) ? ST_SWITCH : ST_REDIRECT;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   // State registers. Thread 1's reset PC carries its thread ID in the top
   // address bit; thread 0 starts at address zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_RUN;
         tid_q     <= '0;
         pc_q[0]   <= '0;
         pc_q[1]   <= {1'b1, {(ADDR_WIDTH-1){1'b0}}};
         blocked_q <= '0;
      end else begin
         state_q   <= state_d;
         tid_q     <= tid_d;
         pc_q      <= pc_d;
         blocked_q <= blocked_d;
      end
   end

   // During the SWITCH cycle the old thread ID is still shown, so fetch picks
   // up the partner's resume PC itself.
   assign bus.o_thread_switch = (state_q == ST_SWITCH);
   assign bus.o_redirect      = (state_q == ST_REDIRECT);
   assign bus.o_flush         = (state_q == ST_SWITCH) || (state_q == ST_REDIRECT);
   assign bus.o_idle          = (state_q == ST_IDLE);
   assign bus.o_thread_id     = tid_q;
   assign bus.o_resume_pc[0]  = pc_q[0];
   assign bus.o_resume_pc[1]  = pc_q[1];
   assign bus.o_redirect_pc   = pc_q[tid_q];
   assign bus.o_blocked       = blocked_q;

endmodule

// File: tb/tb_thread_scheduler.sv
// Self-checking bench for thread_scheduler: directed scenarios followed by a
// randomized run compared cycle by cycle against a behavioural model.
module tb_thread_scheduler;

   localparam int AW = 26;
   localparam int Q  = 8;
   localparam logic [AW-1:0] PC1_RESET = 26'h2000000;

   localparam int M_RUN    = 0;
   localparam int M_HANDOFF = 1;
   localparam int M_WAIT   = 2;
   localparam int M_RELOAD = 3;

   logic clk = 1'b0;
   logic rst;

   int total = 0;
   int bad   = 0;

   int              mMode;
   bit              mActive;
   logic [AW-1:0]   mPc [2];
   bit [1:0]        mBlocked;
   int              mRun;

   // 10 ns clock
   always #5 clk = ~clk;

   thread_scheduler_if #(.ADDR_WIDTH(AW)) bus ();

   thread_scheduler #(
      .ADDR_WIDTH (AW),
      .QUANTUM    (Q)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Watchdog so the run always ends even if something wedges.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs();
      bus.i_switch_req = 1'b0;
      bus.i_restart_pc = '0;
      bus.i_stall      = 1'b0;
      bus.i_event_done = 1'b0;
      bus.i_event_tid  = 1'b0;
   endtask

   // Reference model: thread-level view of who runs, who waits, where each
   // thread resumes and how long the current thread has run unstalled.
   task automatic modelReset();
      mMode    = M_RUN;
      mActive  = 1'b0;
      mPc[0]   = '0;
      mPc[1]   = PC1_RESET;
      mBlocked = 2'b00;
      mRun     = 0;
   endtask

   task automatic modelStep(input logic sw, input logic [AW-1:0] pc, input logic st,
                            input logic ed, input logic tid, input logic r);
      bit [1:0] after;
      int       nextMode;
      if (r) begin
         modelReset();
         return;
      end
      after = mBlocked;
      if (ed) after[tid] = 1'b0;
      nextMode = mMode;
      case (mMode)
         M_RUN: begin
            if (sw) begin
               mPc[mActive]   = pc;
               after[mActive] = 1'b1;
               nextMode       = after[!mActive] ? M_WAIT : M_HANDOFF;
            end else if (mRun == Q - 1 && !st && !after[!mActive]) begin
               mPc[mActive] = pc;
               nextMode     = M_HANDOFF;
            end else if (!st && mRun < Q - 1) begin
               mRun++;
            end
         end
         M_HANDOFF: begin
            mActive  = !mActive;
            nextMode = M_RUN;
         end
         M_WAIT: begin
            if (ed) nextMode = (tid != mActive) ? M_HANDOFF : M_RELOAD;
         end
         default: nextMode = M_RUN;
      endcase
      mBlocked = after;
      if (nextMode != M_RUN) mRun = 0;
      mMode = nextMode;
   endtask

   task automatic doReset();
      rst = 1'b1;
      idleInputs();
      tick();
      tick();
      rst = 1'b0;
      modelReset();
   endtask

   task automatic test_reset();
      doReset();
      bus.i_stall = 1'b1;
      for (int c = 0; c < 10; c++) begin
         total++;
         if (bus.o_thread_id !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_id c=%0d: got %0h want 0", c, bus.o_thread_id);
         end
         total++;
         if (bus.o_resume_pc[1] !== PC1_RESET || bus.o_resume_pc[0] !== '0) begin
            bad++;
            $display("[TB] FAIL reset_pc c=%0d: got %0h/%0h want 0/%0h", c,
                     bus.o_resume_pc[0], bus.o_resume_pc[1], PC1_RESET);
         end
         total++;
         if ({bus.o_thread_switch, bus.o_flush, bus.o_redirect, bus.o_idle, bus.o_blocked} !== 6'b0) begin
            bad++;
            $display("[TB] FAIL reset_pulses c=%0d: got %b want 000000", c,
                     {bus.o_thread_switch, bus.o_flush, bus.o_redirect, bus.o_idle, bus.o_blocked});
         end
         tick();
      end
      bus.i_stall = 1'b0;
   endtask

   task automatic test_event_switch();
      doReset();
      for (int c = 0; c < 5; c++) tick();
      bus.i_switch_req = 1'b1;
      bus.i_restart_pc = 26'h0000040;
      tick();
      idleInputs();
      total++;
      if ({bus.o_thread_switch, bus.o_flush, bus.o_thread_id} !== 3'b110) begin
         bad++;
         $display("[TB] FAIL switch_pulse: got %b want 110",
                  {bus.o_thread_switch, bus.o_flush, bus.o_thread_id});
      end
      total++;
      if (bus.o_resume_pc[0] !== 26'h0000040 || bus.o_blocked !== 2'b01) begin
         bad++;
         $display("[TB] FAIL switch_capture: got pc=%0h blk=%b want pc=40 blk=01",
                  bus.o_resume_pc[0], bus.o_blocked);
      end
      tick();
      total++;
      if (bus.o_thread_id !== 1'b1 || bus.o_thread_switch !== 1'b0) begin
         bad++;
         $display("[TB] FAIL switch_newid: got id=%0h sw=%0h want id=1 sw=0",
                  bus.o_thread_id, bus.o_thread_switch);
      end
   endtask

   task automatic test_idle_resume();
      bus.i_switch_req = 1'b1;
      bus.i_restart_pc = 26'h2000100;
      tick();
      idleInputs();
      total++;
      if (bus.o_idle !== 1'b1 || bus.o_blocked !== 2'b11 || bus.o_resume_pc[1] !== 26'h2000100) begin
         bad++;
         $display("[TB] FAIL idle_enter: got idle=%0h blk=%b pc1=%0h want 1 11 2000100",
                  bus.o_idle, bus.o_blocked, bus.o_resume_pc[1]);
      end
      tick();
      tick();
      total++;
      if (bus.o_idle !== 1'b1 || bus.o_thread_switch !== 1'b0) begin
         bad++;
         $display("[TB] FAIL idle_hold: got idle=%0h sw=%0h want 1 0", bus.o_idle, bus.o_thread_switch);
      end
      bus.i_event_done = 1'b1;
      bus.i_event_tid  = 1'b0;
      tick();
      idleInputs();
      total++;
      if ({bus.o_thread_switch, bus.o_flush, bus.o_idle, bus.o_thread_id, bus.o_blocked} !== 6'b110110) begin
         bad++;
         $display("[TB] FAIL idle_wake: got %b want 110110",
                  {bus.o_thread_switch, bus.o_flush, bus.o_idle, bus.o_thread_id, bus.o_blocked});
      end
      tick();
      total++;
      if (bus.o_thread_id !== 1'b0 || bus.o_redirect_pc !== 26'h0000040 || bus.o_thread_switch !== 1'b0) begin
         bad++;
         $display("[TB] FAIL idle_resume: got id=%0h rpc=%0h sw=%0h want 0 40 0",
                  bus.o_thread_id, bus.o_redirect_pc, bus.o_thread_switch);
      end
   endtask

   task automatic test_redirect();
      bus.i_switch_req = 1'b1;
      bus.i_restart_pc = 26'h0000080;
      tick();
      idleInputs();
      total++;
      if (bus.o_idle !== 1'b1 || bus.o_blocked !== 2'b11) begin
         bad++;
         $display("[TB] FAIL redir_idle: got idle=%0h blk=%b want 1 11", bus.o_idle, bus.o_blocked);
      end
      bus.i_event_done = 1'b1;
      bus.i_event_tid  = 1'b0;
      tick();
      idleInputs();
      total++;
      if ({bus.o_redirect, bus.o_flush, bus.o_thread_switch, bus.o_thread_id, bus.o_blocked} !== 6'b110010
          || bus.o_redirect_pc !== 26'h0000080) begin
         bad++;
         $display("[TB] FAIL redir_pulse: got %b rpc=%0h want 110010 rpc=80",
                  {bus.o_redirect, bus.o_flush, bus.o_thread_switch, bus.o_thread_id, bus.o_blocked},
                  bus.o_redirect_pc);
      end
      tick();
      total++;
      if ({bus.o_redirect, bus.o_flush, bus.o_idle, bus.o_thread_id} !== 4'b0000) begin
         bad++;
         $display("[TB] FAIL redir_end: got %b want 0000",
                  {bus.o_redirect, bus.o_flush, bus.o_idle, bus.o_thread_id});
      end
   endtask

   task automatic test_simultaneous();
      bus.i_switch_req = 1'b1;
      bus.i_restart_pc = 26'h0000044;
      bus.i_event_done = 1'b1;
      bus.i_event_tid  = 1'b1;
      tick();
      idleInputs();
      total++;
      if ({bus.o_thread_switch, bus.o_idle, bus.o_blocked} !== 4'b1001 || bus.o_resume_pc[0] !== 26'h0000044) begin
         bad++;
         $display("[TB] FAIL simul: got %b pc0=%0h want 1001 pc0=44",
                  {bus.o_thread_switch, bus.o_idle, bus.o_blocked}, bus.o_resume_pc[0]);
      end
      tick();
      total++;
      if (bus.o_thread_id !== 1'b1) begin
         bad++;
         $display("[TB] FAIL simul_id: got %0h want 1", bus.o_thread_id);
      end
   endtask

   task automatic test_preempt();
      doReset();
      bus.i_restart_pc = 26'h0000123;
      for (int c = 0; c <= 8; c++) begin
         total++;
         if (bus.o_thread_switch !== (c == 8)) begin
            bad++;
            $display("[TB] FAIL preempt c=%0d: got %0h want %0h", c, bus.o_thread_switch, (c == 8));
         end
         if (c == 8) begin
            total++;
            if (bus.o_thread_id !== 1'b0 || bus.o_resume_pc[0] !== 26'h0000123 || bus.o_blocked !== 2'b00) begin
               bad++;
               $display("[TB] FAIL preempt_cap: got id=%0h pc0=%0h blk=%b want 0 123 00",
                        bus.o_thread_id, bus.o_resume_pc[0], bus.o_blocked);
            end
         end
         tick();
      end
      total++;
      if (bus.o_thread_id !== 1'b1) begin
         bad++;
         $display("[TB] FAIL preempt_id: got %0h want 1", bus.o_thread_id);
      end
      idleInputs();
   endtask

   task automatic test_preempt_stall();
      doReset();
      for (int c = 0; c <= 11; c++) begin
         total++;
         if (bus.o_thread_switch !== (c == 11)) begin
            bad++;
            $display("[TB] FAIL preempt_stall c=%0d: got %0h want %0h", c, bus.o_thread_switch, (c == 11));
         end
         bus.i_stall = (c >= 2 && c <= 4);
         tick();
      end
      idleInputs();
   endtask

   task automatic test_reset_idle();
      doReset();
      bus.i_switch_req = 1'b1;
      bus.i_restart_pc = 26'h0000010;
      tick();
      idleInputs();
      tick();
      bus.i_switch_req = 1'b1;
      bus.i_restart_pc = 26'h2000020;
      tick();
      idleInputs();
      total++;
      if (bus.o_idle !== 1'b1) begin
         bad++;
         $display("[TB] FAIL rst_idle_pre: got %0h want 1", bus.o_idle);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if ({bus.o_idle, bus.o_blocked, bus.o_thread_id, bus.o_thread_switch, bus.o_redirect, bus.o_flush} !== 7'b0
          || bus.o_resume_pc[0] !== '0 || bus.o_resume_pc[1] !== PC1_RESET) begin
         bad++;
         $display("[TB] FAIL rst_idle: got %b pc0=%0h pc1=%0h want 0000000 0 %0h",
                  {bus.o_idle, bus.o_blocked, bus.o_thread_id, bus.o_thread_switch, bus.o_redirect, bus.o_flush},
                  bus.o_resume_pc[0], bus.o_resume_pc[1], PC1_RESET);
      end
      bus.i_switch_req = 1'b1;
      bus.i_restart_pc = 26'h0000030;
      tick();
      idleInputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if ({bus.o_thread_switch, bus.o_flush, bus.o_thread_id, bus.o_blocked} !== 5'b0) begin
         bad++;
         $display("[TB] FAIL rst_switch: got %b want 00000",
                  {bus.o_thread_switch, bus.o_flush, bus.o_thread_id, bus.o_blocked});
      end
   endtask

   task automatic test_random();
      logic          sw, st, ed, tid, r;
      logic [AW-1:0] pc;
      logic [84:0]   got, want;
      doReset();
      for (int i = 0; i < 800; i++) begin
         sw  = ($urandom_range(0, 5) == 0);
         st  = ($urandom_range(0, 3) == 0);
         ed  = ($urandom_range(0, 4) == 0);
         tid = 1'($urandom_range(0, 1));
         r   = ($urandom_range(0, 99) == 0);
         pc  = AW'($urandom);
         bus.i_switch_req = sw;
         bus.i_restart_pc = pc;
         bus.i_stall      = st;
         bus.i_event_done = ed;
         bus.i_event_tid  = tid;
         rst              = r;
         tick();
         modelStep(sw, pc, st, ed, tid, r);
         got  = {bus.o_thread_switch, bus.o_flush, bus.o_idle, bus.o_redirect, bus.o_thread_id,
                 bus.o_blocked, bus.o_resume_pc[0], bus.o_resume_pc[1], bus.o_redirect_pc};
         want = {mMode == M_HANDOFF, (mMode == M_HANDOFF) || (mMode == M_RELOAD), mMode == M_WAIT,
                 mMode == M_RELOAD, mActive, mBlocked, mPc[0], mPc[1], mPc[mActive]};
         total++;
         if (got !== want) begin
            bad++;
            $display("[TB] FAIL random i=%0d: got %h want %h", i, got, want);
         end
      end
      rst = 1'b0;
      idleInputs();
   endtask

   initial begin
      rst = 1'b1;
      idleInputs();
      test_reset();
      test_event_switch();
      test_idle_resume();
      test_redirect();
      test_simultaneous();
      test_preempt();
      test_preempt_stall();
      test_reset_idle();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
